wm: RTL and testbench
=====================

# wm

Automatic washing-machine sequencer. On a start request it runs a fixed programme of three phases (wash, then rinse, then spin), each lasting a parameterised number of clock cycles, then returns to idle. It sits between the front-panel start input and the motor/valve drivers, which consume its one-hot phase outputs directly.

## Interface

Parameters:
- WASH_CYCLES, default 3: clock cycles the wash phase lasts (must be ≥ 1).
- RINSE_CYCLES, default 2: clock cycles the rinse phase lasts (must be ≥ 1).
- SPIN_CYCLES, default 2: clock cycles the spin phase lasts (must be ≥ 1).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- start  input  1  programme start request, sampled on rising clk edge; single-cycle pulse sufficient.
- wash  output  1  high while in WASH phase.
- rinse  output  1  high while in RINSE phase.
- spin  output  1  high while in SPIN phase.

## Operation

- Moore FSM, states IDLE, WASH, RINSE, SPIN; registered state plus a phase cycle counter.
- Counter width: enough bits to hold max(WASH_CYCLES, RINSE_CYCLES, SPIN_CYCLES) − 1; counts 0 up to N−1 within a phase; cleared on every phase entry.
- Transitions:
  - IDLE: start=1 → WASH; else stay.
  - WASH: counter = WASH_CYCLES−1 → RINSE; else increment.
  - RINSE: counter = RINSE_CYCLES−1 → SPIN; else increment.
  - SPIN: counter = SPIN_CYCLES−1 → IDLE; else increment.
- Outputs decoded from state only: wash = (state==WASH), rinse = (state==RINSE), spin = (state==SPIN). Outputs are mutually exclusive; all 0 in IDLE.
- start ignored in WASH/RINSE/SPIN; no queuing, no abort via start.
- Illegal/unreachable state encodings recover to IDLE on the next edge with counter cleared.
- Parameters < 1 are unsupported; elaboration must fail (generate-time check).

## Timing

- Reset (reset=0): state=IDLE, counter=0, wash=rinse=spin=0 immediately, independent of clk; held while reset low. First transition possible on first rising edge after reset returns high.
- Latency: start sampled high at edge E → wash high from E for exactly WASH_CYCLES cycles, rinse for RINSE_CYCLES cycles, spin for SPIN_CYCLES cycles, then all low.
- Total programme: WASH_CYCLES+RINSE_CYCLES+SPIN_CYCLES cycles of activity (7 with defaults).
- Phase boundaries are gap-free: the edge that drops wash raises rinse; same for rinse→spin.
- After SPIN, at least one IDLE cycle always occurs; start held high continuously therefore restarts WASH one cycle after spin drops.
- start asserted on the same edge the FSM enters IDLE from SPIN is not seen (FSM was in SPIN when sampled).
- Reset asserted mid-phase aborts immediately to IDLE; no phase resumes after release without a new start.

## Test plan

- Reset: hold reset=0 with start toggling → wash=rinse=spin=0 throughout, no phase entered; release reset with start=0 → stays idle.
- Nominal run (defaults): reset released, one-cycle start pulse → wash high 3 cycles, rinse high 2, spin high 2, contiguous, then all 0 and remain 0 for ≥ 10 cycles.
- Start during run: pulse start again during wash and during spin → sequence timing unchanged, no second programme.
- Start held high: start=1 continuously → programme repeats with exactly one all-low cycle between spin and next wash.
- Mid-run reset: assert reset=0 asynchronously (between edges) during rinse → rinse drops without waiting for clk; after release, outputs stay 0 until new start.
- Parameter sweep: WASH_CYCLES=1, RINSE_CYCLES=5, SPIN_CYCLES=1 → wash 1 cycle, rinse 5, spin 1; verify one-hot outputs every cycle.

Source files
------------

// File: rtl/wm.sv
// wm: washing-machine sequencer running wash, rinse and spin phases of
// parameterised length after a start request, with one-hot phase outputs.
module wm #(
    parameter int WASH_CYCLES  = 3,
    parameter int RINSE_CYCLES = 2,
    parameter int SPIN_CYCLES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic wash,
    output logic rinse,
    output logic spin
);
    localparam int MAX_CYCLES = (WASH_CYCLES > RINSE_CYCLES)
                              ? ((WASH_CYCLES > SPIN_CYCLES) ? WASH_CYCLES : SPIN_CYCLES)
                              : ((RINSE_CYCLES > SPIN_CYCLES) ? RINSE_CYCLES : SPIN_CYCLES);
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] WASH_LAST  = CW'(WASH_CYCLES - 1);
    localparam logic [CW-1:0] RINSE_LAST = CW'(RINSE_CYCLES - 1);
    localparam logic [CW-1:0] SPIN_LAST  = CW'(SPIN_CYCLES - 1);

    generate
        if (WASH_CYCLES < 1 || RINSE_CYCLES < 1 || SPIN_CYCLES < 1) begin : g_bad_params
            $error("wm: every phase must last at least one cycle");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WASH, RINSE, SPIN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter clears on every phase entry; within a phase it counts up.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = start ? WASH : IDLE;
            end
            WASH: if (cnt_q == WASH_LAST) begin
                state_d = RINSE;
                cnt_d   = '0;
            end
            RINSE: if (cnt_q == RINSE_LAST) begin
                state_d = SPIN;
                cnt_d   = '0;
            end
            SPIN: if (cnt_q == SPIN_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wash  = (state_q == WASH);
        rinse = (state_q == RINSE);
        spin  = (state_q == SPIN);
    end
endmodule

// File: tb/tb_wm.sv
// tb_wm: randomized and directed checks of two wm instances (default and
// 1/5/1 phase lengths) against a programme-timeline reference model.
module tb_wm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic w1, r1, s1, w2, r2, s2;

    int checks = 0;
    int errors = 0;

    bit a1 = 0, a2 = 0;
    int t1 = 0, t2 = 0;

    always #5 clk = ~clk;

    wm dut1 (.clk(clk), .reset(reset), .start(start), .wash(w1), .rinse(r1), .spin(s1));
    wm #(.WASH_CYCLES(1), .RINSE_CYCLES(5), .SPIN_CYCLES(1)) dut2
        (.clk(clk), .reset(reset), .start(start), .wash(w2), .rinse(r2), .spin(s2));

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Timeline model: a programme is "active" for w+r+s cycles after start.
    function automatic logic [2:0] exp_out(input int w, r, s, input bit act, input int t);
        if (!act) return 3'b000;
        return {t < w, t >= w && t < w + r, t >= w + r && t < w + r + s};
    endfunction

    task automatic model_step(input int w, r, s, input logic st, inout bit act, inout int t);
        if (act) begin
            t++;
            if (t == w + r + s) act = 0;
        end else if (st) begin
            act = 1;
            t = 0;
        end
    endtask

    task automatic compare();
        check("dflt", {w1, r1, s1}, exp_out(3, 2, 2, a1, t1));
        check("sweep", {w2, r2, s2}, exp_out(1, 5, 1, a2, t2));
        check("onehot_dflt", {2'b00, $onehot0({w1, r1, s1})}, 3'b001);
        check("onehot_sweep", {2'b00, $onehot0({w2, r2, s2})}, 3'b001);
    endtask

    task automatic cycle(input logic st, input logic rs);
        @(negedge clk);
        start = st;
        reset = rs;
        if (!rs) begin
            a1 = 0; a2 = 0; t1 = 0; t2 = 0;
        end
        @(posedge clk);
        if (reset) begin
            model_step(3, 2, 2, start, a1, t1);
            model_step(1, 5, 1, start, a2, t2);
        end
        #1;
        compare();
    endtask

    // Asserts reset between edges and checks outputs drop without a clock.
    task automatic abort();
        #2;
        reset = 1'b0;
        #1;
        a1 = 0; a2 = 0; t1 = 0; t2 = 0;
        check("async_dflt", {w1, r1, s1}, 3'b000);
        check("async_sweep", {w2, r2, s2}, 3'b000);
    endtask

    initial begin
        #1;
        check("reset_dflt", {w1, r1, s1}, 3'b000);
        check("reset_sweep", {w2, r2, s2}, 3'b000);
        for (int i = 0; i < 6; i++) cycle(logic'(i % 2 == 0), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cycle(logic'(i == 1 || i == 5), 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("in_rinse", {w1, r1, s1}, 3'b010);
        abort();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            cycle(logic'($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 40) == 0) begin
                abort();
                cycle(logic'($urandom_range(0, 1)), 1'b0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
